// File: rtl/pwm_sched_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_sched_ctrl
//  Description : Scheduler for a bank of PWM channels that share one
//                free-running period counter. It starts and stops the
//                counter, and it holds the duty value for each channel.
//                A duty written while running goes to a shadow register.
//                The shadow value is copied to the active register only at
//                a period boundary (the wrap cycle), so the output pins
//                never glitch.
//                Optional macro PWM_PERIOD_IRQ_EN adds the period_done
//                output, which pulses high on every wrap cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_sched_ctrl #(
  parameter  int N_CH = 4,
  parameter  int W    = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [W-1:0]      period,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [W-1:0]      cfg_duty,
  output logic [W-1:0]      count,
  output logic [N_CH-1:0]   pw,
`ifdef PWM_PERIOD_IRQ_EN
  output logic              period_done,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [CH_W:0] NCH_C = (CH_W+1)'(N_CH);

  state_t            state;
  state_t            state_nxt;
  logic [W-1:0]      per_q;
  logic [W-1:0]      shadow  [N_CH];
  logic [W-1:0]      active  [N_CH];
  logic [N_CH-1:0]   pending;
  logic [N_CH-1:0]   ch_sel;
  logic              ch_ok;
  logic              wrap;
  logic              wr_en;

  // The last count of the period. This test is only used while the block is running.
  assign wrap  = (count == per_q);
  assign busy  = (state != ST_IDLE);
  assign wr_en = cfg_valid && cfg_ready;
  // If the channel number is out of range, no channel is selected.
  // A write to that channel is accepted and then discarded.
  assign ch_ok = ({1'b0, cfg_ch} < NCH_C);

  // Decode the channel number into a one-hot select vector.
  always_comb begin
    ch_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch_sel[i] = ch_ok && (cfg_ch == CH_W'(i));
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and config handshake. cfg_ready does not depend on cfg_valid.
  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (start && !stop) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // Block a second write to a channel until its first write has been applied.
        cfg_ready = ~|(ch_sel & pending);
        if (stop) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (wrap) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Period counter, latched period, and the per-channel duty registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      per_q   <= '0;
      pending <= '0;
      for (int i = 0; i < N_CH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (state == ST_IDLE) begin
        count <= '0;
        if (start && !stop) per_q <= period;
      end else begin
        count <= wrap ? '0 : count + W'(1);
      end
      for (int i = 0; i < N_CH; i++) begin
        // On the wrap cycle, copy each pending shadow value into its active register.
        if (state != ST_IDLE && wrap && pending[i]) begin
          active[i]  <= shadow[i];
          pending[i] <= 1'b0;
        end
        // A write made on the wrap cycle sees pending=0 above.
        // So it stays pending and is applied at the next wrap.
        if (wr_en && ch_sel[i]) begin
          shadow[i] <= cfg_duty;
          if (state == ST_IDLE) begin
            active[i] <= cfg_duty;
          end else begin
            pending[i] <= 1'b1;
          end
        end
      end
    end
  end

  // PWM outputs are decoded from registers, so they add no extra cycle of latency.
  always_comb begin
    pw = '0;
    for (int i = 0; i < N_CH; i++) begin
      pw[i] = busy && (count < active[i]);
    end
  end

`ifdef PWM_PERIOD_IRQ_EN
  // One-cycle pulse on every wrap cycle, including the final wrap in DRAIN.
  assign period_done = busy && wrap;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_sched_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_sched_ctrl
//  Description : Self-checking bench for pwm_sched_ctrl with a
//                scoreboard of expected per-cycle outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_sched_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] period = 4'd0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = 2'd0;
  logic [3:0] cfg_duty = 4'd0;
  logic [3:0] count;
  logic [3:0] pw;
  logic       busy;
`ifdef PWM_PERIOD_IRQ_EN
  logic       period_done;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] cnt;
    logic [3:0] pw;
    logic       busy;
    logic       rdy;
    logic       pd;
  } exp_t;

  exp_t sb[$];

  pwm_sched_ctrl #(.N_CH(4), .W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .period     (period),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_duty   (cfg_duty),
    .count      (count),
    .pw         (pw),
`ifdef PWM_PERIOD_IRQ_EN
    .period_done(period_done),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_ch = 2'd0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic idle_write(input logic [1:0] ch, input logic [3:0] d);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_duty = d;
    step();
    cfg_valid = 1'b0; cfg_ch = 2'd0;
  endtask

  task automatic launch(input logic [3:0] p);
    period = p; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic exp_t mk(input logic [3:0] c, input logic [3:0] p,
                              input logic b, input logic r, input logic pd);
    exp_t e;
    e.cnt = c; e.pw = p; e.busy = b; e.rdy = r; e.pd = pd;
    return e;
  endfunction

  task automatic test_reset();
    step(); step();
    checks++;
    if ({count, pw, busy, cfg_ready} !== {4'd0, 4'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_init: got cnt=%0d pw=%b busy=%b rdy=%b want 0 0000 0 1", count, pw, busy, cfg_ready);
    end
    reset = 1'b0;
    idle_write(2'd0, 4'd3);
    launch(4'd7);
    step(); step(); step();
    checks++;
    if ({count, busy} !== {4'd3, 1'b1}) begin
      failures++;
      $display("FAIL reset_prerun: got cnt=%0d busy=%b want 3 1", count, busy);
    end
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({count, pw, busy, cfg_ready} !== {4'd0, 4'd0, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL reset_mid_run[%0d]: got cnt=%0d pw=%b busy=%b rdy=%b want 0 0000 0 1", k, count, pw, busy, cfg_ready);
      end
    end
    reset = 1'b0;
    launch(4'd7);
    checks++;
    if ({count, pw, busy} !== {4'd0, 4'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_active_cleared: got cnt=%0d pw=%b busy=%b want 0 0000 1", count, pw, busy);
    end
  endtask

  task automatic test_idle_cfg();
    exp_t e;
    logic [3:0] c;
    do_reset();
    idle_write(2'd0, 4'd3); idle_write(2'd1, 4'd0);
    idle_write(2'd2, 4'd8); idle_write(2'd3, 4'd15);
    launch(4'd7);
    for (int k = 0; k < 20; k++) begin
      c = 4'(k % 8);
      sb.push_back(mk(c, {1'b1, 1'b1, 1'b0, c < 4'd3}, 1'b1, 1'b1, c == 4'd7));
    end
    for (int k = 0; sb.size() > 0; k++) begin
      e = sb.pop_front();
      checks++;
      if ({count, pw, busy, cfg_ready} !== {e.cnt, e.pw, e.busy, e.rdy}) begin
        failures++;
        $display("FAIL idle_cfg[%0d]: got cnt=%0d pw=%b busy=%b rdy=%b want cnt=%0d pw=%b busy=%b rdy=%b", k, count, pw, busy, cfg_ready, e.cnt, e.pw, e.busy, e.rdy);
      end
`ifdef PWM_PERIOD_IRQ_EN
      checks++;
      if (period_done !== e.pd) begin failures++; $display("FAIL idle_cfg_pd[%0d]: got %b want %b", k, period_done, e.pd); end
`endif
      step();
    end
  endtask

  task automatic test_shadow();
    exp_t e;
    logic [3:0] c;
    logic [3:0] a;
    do_reset();
    idle_write(2'd0, 4'd3);
    launch(4'd7);
    step(); step();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_duty = 4'd6;
    checks++;
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL shadow_rdy_first: got %b want 1", cfg_ready); end
    step();
    cfg_duty = 4'd9;
    checks++;
    if (cfg_ready !== 1'b0) begin failures++; $display("FAIL shadow_rdy_second: got %b want 0", cfg_ready); end
    cfg_valid = 1'b0;
    for (int j = 0; j < 13; j++) begin
      c = 4'((3 + j) % 8);
      a = (j >= 5) ? 4'd6 : 4'd3;
      sb.push_back(mk(c, {3'b000, c < a}, 1'b1, j >= 5, c == 4'd7));
    end
    for (int k = 0; sb.size() > 0; k++) begin
      e = sb.pop_front();
      checks++;
      if ({count, pw, busy, cfg_ready} !== {e.cnt, e.pw, e.busy, e.rdy}) begin
        failures++;
        $display("FAIL shadow[%0d]: got cnt=%0d pw=%b busy=%b rdy=%b want cnt=%0d pw=%b busy=%b rdy=%b", k, count, pw, busy, cfg_ready, e.cnt, e.pw, e.busy, e.rdy);
      end
      step();
    end
  endtask

  task automatic test_wrap_write();
    exp_t e;
    logic [3:0] c;
    logic [3:0] a;
    do_reset();
    launch(4'd7);
    for (int k = 0; k < 7; k++) step();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_duty = 4'd5;
    checks++;
    if ({count, cfg_ready} !== {4'd7, 1'b1}) begin
      failures++;
      $display("FAIL wrap_write_setup: got cnt=%0d rdy=%b want 7 1", count, cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    for (int j = 0; j < 16; j++) begin
      c = 4'(j % 8);
      a = (j >= 8) ? 4'd5 : 4'd0;
      sb.push_back(mk(c, {2'b00, c < a, 1'b0}, 1'b1, j >= 8, c == 4'd7));
    end
    for (int k = 0; sb.size() > 0; k++) begin
      e = sb.pop_front();
      checks++;
      if ({count, pw, busy, cfg_ready} !== {e.cnt, e.pw, e.busy, e.rdy}) begin
        failures++;
        $display("FAIL wrap_write[%0d]: got cnt=%0d pw=%b busy=%b rdy=%b want cnt=%0d pw=%b busy=%b rdy=%b", k, count, pw, busy, cfg_ready, e.cnt, e.pw, e.busy, e.rdy);
      end
      step();
    end
    cfg_ch = 2'd0;
  endtask

  task automatic test_stop_drain();
    exp_t e;
    do_reset();
    idle_write(2'd0, 4'd3);
    launch(4'd7);
    step(); step(); step();
    stop = 1'b1;
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_duty = 4'd7;
    checks++;
    if ({count, pw, busy, cfg_ready} !== {4'd3, 4'd0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL stop_at3: got cnt=%0d pw=%b busy=%b rdy=%b want 3 0000 1 1", count, pw, busy, cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    for (int j = 4; j < 8; j++) sb.push_back(mk(4'(j), 4'd0, 1'b1, 1'b0, j == 7));
    sb.push_back(mk(4'd0, 4'd0, 1'b0, 1'b1, 1'b0));
    sb.push_back(mk(4'd0, 4'd0, 1'b0, 1'b1, 1'b0));
    for (int k = 0; sb.size() > 0; k++) begin
      e = sb.pop_front();
      checks++;
      if ({count, pw, busy, cfg_ready} !== {e.cnt, e.pw, e.busy, e.rdy}) begin
        failures++;
        $display("FAIL drain[%0d]: got cnt=%0d pw=%b busy=%b rdy=%b want cnt=%0d pw=%b busy=%b rdy=%b", k, count, pw, busy, cfg_ready, e.cnt, e.pw, e.busy, e.rdy);
      end
`ifdef PWM_PERIOD_IRQ_EN
      checks++;
      if (period_done !== e.pd) begin failures++; $display("FAIL drain_pd[%0d]: got %b want %b", k, period_done, e.pd); end
`endif
      step();
    end
    start = 1'b1;
    step();
    checks++;
    if ({count, busy} !== {4'd0, 1'b0}) begin
      failures++;
      $display("FAIL start_stop_idle: got cnt=%0d busy=%b want 0 0", count, busy);
    end
    start = 1'b0; stop = 1'b0;
    launch(4'd7);
    for (int k = 0; k < 5; k++) step();
    checks++;
    if ({count, pw} !== {4'd5, 4'b0001}) begin
      failures++;
      $display("FAIL drain_applied: got cnt=%0d pw=%b want 5 0001", count, pw);
    end
  endtask

  task automatic test_period_edges();
    exp_t e;
    logic [3:0] c;
    do_reset();
    idle_write(2'd0, 4'd1);
    launch(4'd0);
    for (int j = 0; j < 6; j++) sb.push_back(mk(4'd0, 4'b0001, 1'b1, 1'b1, 1'b1));
    do begin
      e = sb.pop_front();
      checks++;
      if ({count, pw, busy, cfg_ready} !== {e.cnt, e.pw, e.busy, e.rdy}) begin
        failures++;
        $display("FAIL period0: got cnt=%0d pw=%b busy=%b rdy=%b want cnt=%0d pw=%b busy=%b rdy=%b", count, pw, busy, cfg_ready, e.cnt, e.pw, e.busy, e.rdy);
      end
`ifdef PWM_PERIOD_IRQ_EN
      checks++;
      if (period_done !== e.pd) begin failures++; $display("FAIL period0_pd: got %b want %b", period_done, e.pd); end
`endif
      step();
    end while (sb.size() > 0);
    do_reset();
    idle_write(2'd0, 4'd1);
    launch(4'd15);
    for (int j = 0; j < 34; j++) begin
      c = 4'(j % 16);
      sb.push_back(mk(c, {3'b000, c == 4'd0}, 1'b1, 1'b1, c == 4'd15));
    end
    for (int k = 0; sb.size() > 0; k++) begin
      e = sb.pop_front();
      checks++;
      if ({count, pw, busy, cfg_ready} !== {e.cnt, e.pw, e.busy, e.rdy}) begin
        failures++;
        $display("FAIL period15[%0d]: got cnt=%0d pw=%b busy=%b rdy=%b want cnt=%0d pw=%b busy=%b rdy=%b", k, count, pw, busy, cfg_ready, e.cnt, e.pw, e.busy, e.rdy);
      end
`ifdef PWM_PERIOD_IRQ_EN
      checks++;
      if (period_done !== e.pd) begin failures++; $display("FAIL period15_pd[%0d]: got %b want %b", k, period_done, e.pd); end
`endif
      step();
    end
  endtask

  initial begin
    test_reset();
    test_idle_cfg();
    test_shadow();
    test_wrap_write();
    test_stop_drain();
    test_period_edges();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
